// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: shared baud tick, framed TX, and a 16x-oversampled RX
// with synchroniser, start-bit glitch rejection, sticky error flags and break hold-off.
module uart_core_param #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_100m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    input  logic                 rx_ready_clr,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OCW     = $clog2(OVERSAMPLE);
    localparam int BCW     = 4;

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [OCW-1:0] OS_LAST   = OCW'(OVERSAMPLE - 1);
    localparam logic [OCW-1:0] OS_HALF   = OCW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_ARM   = 3'd1;
    localparam logic [2:0] TX_START = 3'd2;
    localparam logic [2:0] TX_DATA  = 3'd3;
    localparam logic [2:0] TX_PAR   = 3'd4;
    localparam logic [2:0] TX_STOP  = 3'd5;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_PAR   = 3'd3;
    localparam logic [2:0] RX_STOP  = 3'd4;
    localparam logic [2:0] RX_BREAK = 3'd5;

    // Odd parity inverts the XOR so the total count of ones including the parity bit is odd.
    function automatic logic parity_calc(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 1) begin
            parity_calc = ~p;
        end else begin
            parity_calc = p;
        end
    endfunction

    logic [DCW-1:0]       div_cnt_r;
    logic                 tick_s;

    logic [2:0]           tx_state_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic [OCW-1:0]       tx_cnt_r;
    logic [BCW-1:0]       tx_bit_r;
    logic                 tx_r;
    logic                 tx_busy_r;
    logic                 tx_bit_end_s;

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic [2:0]           rx_state_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_bit_r;
    logic [OCW-1:0]       rx_cnt_r;
    logic [BCW-1:0]       rx_bit_r;
    logic                 rx_bit_end_s;
    logic                 rx_half_s;
    logic                 rx_done_s;
    logic                 rx_par_err_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_ready_r;
    logic                 rx_frame_err_r;
    logic                 rx_parity_err_r;
    logic                 rx_overrun_r;

    assign tick_s       = (div_cnt_r == DIV_LAST);
    assign tx_bit_end_s = tick_s && (tx_cnt_r == OS_LAST);
    assign rx_bit_end_s = tick_s && (rx_cnt_r == OS_LAST);
    assign rx_half_s    = tick_s && (rx_cnt_r == OS_HALF);
    assign rx_done_s    = (rx_state_r == RX_STOP) && rx_bit_end_s;

    // Parity mismatch of the frame currently being closed; never flagged when parity is off.
    always_comb begin
        rx_par_err_s = 1'b0;
        if (PARITY != 0) begin
            rx_par_err_s = (rx_par_bit_r != parity_calc(rx_shift_r));
        end else begin
            rx_par_err_s = 1'b0;
        end
    end

    // Free-running oversample tick divider shared by both directions.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DCW'(1);
        end
    end

    // Transmit FSM; ARM holds the latched word until the next tick so the start bit is full length.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            if (tick_s) begin
                tx_cnt_r <= tx_bit_end_s ? '0 : tx_cnt_r + OCW'(1);
            end
            case (tx_state_r)
                TX_IDLE: begin
                    tx_r <= 1'b1;
                    if (tx_start && !tx_busy_r) begin
                        tx_shift_r <= tx_data;
                        tx_par_r   <= parity_calc(tx_data);
                        tx_busy_r  <= 1'b1;
                        tx_state_r <= TX_ARM;
                    end
                end
                TX_ARM: begin
                    if (tick_s) begin
                        tx_r       <= 1'b0;
                        tx_cnt_r   <= '0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_r       <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                        tx_bit_r   <= '0;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_s) begin
                        if (tx_bit_r == DATA_LAST) begin
                            tx_bit_r <= '0;
                            if (PARITY != 0) begin
                                tx_r       <= tx_par_r;
                                tx_state_r <= TX_PAR;
                            end else begin
                                tx_r       <= 1'b1;
                                tx_state_r <= TX_STOP;
                            end
                        end else begin
                            tx_r       <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                            tx_bit_r   <= tx_bit_r + BCW'(1);
                        end
                    end
                end
                TX_PAR: begin
                    if (tx_bit_end_s) begin
                        tx_r       <= 1'b1;
                        tx_bit_r   <= '0;
                        tx_state_r <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end_s) begin
                        if (tx_bit_r == STOP_LAST) begin
                            tx_busy_r  <= 1'b0;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_bit_r <= tx_bit_r + BCW'(1);
                        end
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    tx_busy_r  <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM; samples at bit centres, and after a low stop bit holds in BREAK until the line idles.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            rx_state_r   <= RX_IDLE;
            rx_shift_r   <= '0;
            rx_par_bit_r <= 1'b0;
            rx_cnt_r     <= '0;
            rx_bit_r     <= '0;
        end else begin
            if (tick_s) begin
                rx_cnt_r <= rx_bit_end_s ? '0 : rx_cnt_r + OCW'(1);
            end
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half_s) begin
                        rx_cnt_r <= '0;
                        rx_bit_r <= '0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end_s) begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                        if (rx_bit_r == DATA_LAST) begin
                            rx_state_r <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + BCW'(1);
                        end
                    end
                end
                RX_PAR: begin
                    if (rx_bit_end_s) begin
                        rx_par_bit_r <= rx_sync_r;
                        rx_state_r   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end_s) begin
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    rx_cnt_r <= '0;
                    if (rx_sync_r) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky status; a completing frame takes priority over a simultaneous clear.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            rx_data_r       <= '0;
            rx_ready_r      <= 1'b0;
            rx_frame_err_r  <= 1'b0;
            rx_parity_err_r <= 1'b0;
            rx_overrun_r    <= 1'b0;
        end else if (rx_done_s) begin
            rx_data_r       <= rx_shift_r;
            rx_ready_r      <= 1'b1;
            rx_overrun_r    <= (rx_ready_clr ? 1'b0 : rx_overrun_r) | rx_ready_r;
            rx_frame_err_r  <= (rx_ready_clr ? 1'b0 : rx_frame_err_r) | ~rx_sync_r;
            rx_parity_err_r <= (rx_ready_clr ? 1'b0 : rx_parity_err_r) | rx_par_err_s;
        end else if (rx_ready_clr) begin
            rx_ready_r      <= 1'b0;
            rx_frame_err_r  <= 1'b0;
            rx_parity_err_r <= 1'b0;
            rx_overrun_r    <= 1'b0;
        end else begin
            rx_ready_r      <= rx_ready_r;
        end
    end

    assign tx            = tx_r;
    assign tx_busy       = tx_busy_r;
    assign rx_data       = rx_data_r;
    assign rx_ready      = rx_ready_r;
    assign rx_frame_err  = rx_frame_err_r;
    assign rx_parity_err = rx_parity_err_r;
    assign rx_overrun    = rx_overrun_r;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench: default-rate loopback, plus fast-tick instances for 8E2, 8N1 and 7N1 framing.
module tb_uart_core_param;

    localparam int BIT_D = 864;
    localparam int DIV_D = 54;
    localparam int BIT_F = 32;
    localparam int DIV_F = 2;

    logic clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] tx_data_a, tx_data_b, tx_data_c, rx_data_a, rx_data_b, rx_data_c;
    logic [6:0] tx_data_d, rx_data_d;
    logic tx_start_a, tx_start_b, tx_start_c, tx_start_d;
    logic tx_busy_a, tx_busy_b, tx_busy_c, tx_busy_d;
    logic tx_a, tx_b, tx_c, tx_d;
    logic rx_b, rx_c;
    logic rdy_a, rdy_b, rdy_c, rdy_d;
    logic clr_a, clr_b, clr_c, clr_d;
    logic fe_a, fe_b, fe_c, fe_d;
    logic pe_a, pe_b, pe_c, pe_d;
    logic ov_a, ov_b, ov_c, ov_d;

    uart_core_param u_a (
        .clk_100m(clk_100m), .rst_n(rst_n), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .tx_busy(tx_busy_a), .tx(tx_a), .rx(tx_a), .rx_data(rx_data_a), .rx_ready(rdy_a),
        .rx_ready_clr(clr_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a));

    uart_core_param #(.CLK_HZ(3200000), .BAUD(100000), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk_100m(clk_100m), .rst_n(rst_n), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_busy(tx_busy_b), .tx(tx_b), .rx(rx_b), .rx_data(rx_data_b), .rx_ready(rdy_b),
        .rx_ready_clr(clr_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b));

    uart_core_param #(.CLK_HZ(3200000), .BAUD(100000)) u_c (
        .clk_100m(clk_100m), .rst_n(rst_n), .tx_data(tx_data_c), .tx_start(tx_start_c),
        .tx_busy(tx_busy_c), .tx(tx_c), .rx(rx_c), .rx_data(rx_data_c), .rx_ready(rdy_c),
        .rx_ready_clr(clr_c), .rx_frame_err(fe_c), .rx_parity_err(pe_c), .rx_overrun(ov_c));

    uart_core_param #(.CLK_HZ(3200000), .BAUD(100000), .DATA_BITS(7)) u_d (
        .clk_100m(clk_100m), .rst_n(rst_n), .tx_data(tx_data_d), .tx_start(tx_start_d),
        .tx_busy(tx_busy_d), .tx(tx_d), .rx(tx_d), .rx_data(rx_data_d), .rx_ready(rdy_d),
        .rx_ready_clr(clr_d), .rx_frame_err(fe_d), .rx_parity_err(pe_d), .rx_overrun(ov_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        case (sel)
            0:       cur_tx = tx_a;
            1:       cur_tx = tx_b;
            2:       cur_tx = tx_c;
            default: cur_tx = tx_d;
        endcase
    endfunction

    function automatic logic cur_busy(input int sel);
        case (sel)
            0:       cur_busy = tx_busy_a;
            1:       cur_busy = tx_busy_b;
            2:       cur_busy = tx_busy_c;
            default: cur_busy = tx_busy_d;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin tx_start_a = v; tx_data_a = d; end
            1:       begin tx_start_b = v; tx_data_b = d; end
            2:       begin tx_start_c = v; tx_data_c = d; end
            default: begin tx_start_d = v; tx_data_d = d[6:0]; end
        endcase
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 1) rx_b = v;
        else          rx_c = v;
    endtask

    // Starts a frame, counts busy cycles and samples the line at each bit centre.
    task automatic run_tx(input int sel, input logic [7:0] d, input int bitc, input bit dup,
                          output int busy_n, output logic [15:0] bits);
        int t;
        int k;
        int guard;
        busy_n = 0;
        bits   = 16'hFFFF;
        t      = -1;
        k      = 0;
        guard  = 0;
        @(negedge clk_100m);
        set_start(sel, 1'b1, d);
        @(negedge clk_100m);
        set_start(sel, 1'b0, d);
        while (cur_busy(sel) && guard < 20000) begin
            busy_n++;
            guard++;
            if (t < 0 && cur_tx(sel) == 1'b0) t = 0;
            if (t >= 0) begin
                if ((t % bitc) == bitc / 2 && k < 16) begin
                    bits[k] = cur_tx(sel);
                    k++;
                end
                t++;
            end
            if (dup && t == 2 * bitc) set_start(sel, 1'b1, 8'h7E);
            else                      set_start(sel, 1'b0, d);
            @(negedge clk_100m);
        end
        check("tx_done", {31'd0, cur_busy(sel)}, 32'd0);
    endtask

    task automatic drive_frame(input int sel, input logic [15:0] bits, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            set_rx(sel, bits[k]);
            repeat (BIT_F) @(negedge clk_100m);
        end
    endtask

    task automatic pulse_clr_c();
        clr_c = 1'b1;
        @(negedge clk_100m);
        clr_c = 1'b0;
        @(negedge clk_100m);
    endtask

    int          busy_n;
    logic [15:0] bits;
    int          seen;

    initial begin
        rst_n = 1'b0;
        rx_b = 1'b1; rx_c = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0; clr_d = 1'b0;
        set_start(0, 1'b0, 8'h00); set_start(1, 1'b0, 8'h00);
        set_start(2, 1'b0, 8'h00); set_start(3, 1'b0, 8'h00);
        repeat (3) @(negedge clk_100m);
        check("rst_tx_a",    {31'd0, tx_a}, 32'd1);
        check("rst_busy_a",  {31'd0, tx_busy_a}, 32'd0);
        check("rst_data_a",  {24'd0, rx_data_a}, 32'd0);
        check("rst_flags_a", {28'd0, rdy_a, fe_a, pe_a, ov_a}, 32'd0);
        check("rst_flags_c", {28'd0, rdy_c, fe_c, pe_c, ov_c}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_100m);

        // Default-rate 8N1 loopback
        run_tx(0, 8'hA5, BIT_D, 1'b0, busy_n, bits);
        check("a_tx_frame", {22'd0, bits[9:0]}, 32'h34A);
        check("a_busy_len", {31'd0, (busy_n >= 10*BIT_D && busy_n <= 10*BIT_D + DIV_D)}, 32'd1);
        check("a_rx_data",  {24'd0, rx_data_a}, 32'hA5);
        check("a_rx_ready", {31'd0, rdy_a}, 32'd1);
        check("a_rx_errs",  {29'd0, fe_a, pe_a, ov_a}, 32'd0);

        // 8E2: transmitted frame, then received frame with a flipped parity bit
        run_tx(1, 8'h3C, BIT_F, 1'b0, busy_n, bits);
        check("b_tx_frame", {20'd0, bits[11:0]}, 32'hC78);
        check("b_par_bit",  {31'd0, bits[9]}, 32'd0);
        check("b_busy_len", {31'd0, (busy_n >= 12*BIT_F && busy_n <= 12*BIT_F + DIV_F)}, 32'd1);
        drive_frame(1, 16'h0E78, 12);
        check("b_parity_err", {31'd0, pe_b}, 32'd1);
        check("b_rx_data",    {24'd0, rx_data_b}, 32'h3C);
        check("b_rx_ready",   {31'd0, rdy_b}, 32'd1);
        check("b_frame_err",  {31'd0, fe_b}, 32'd0);

        // Start-bit glitch of ~0.3 bit, then a clean 0x55
        set_rx(2, 1'b0);
        repeat (10) @(negedge clk_100m);
        set_rx(2, 1'b1);
        repeat (2*BIT_F) @(negedge clk_100m);
        check("c_glitch_ready", {31'd0, rdy_c}, 32'd0);
        check("c_glitch_flags", {29'd0, fe_c, pe_c, ov_c}, 32'd0);
        drive_frame(2, 16'h02AA, 10);
        check("c_rx55_data",  {24'd0, rx_data_c}, 32'h55);
        check("c_rx55_ready", {31'd0, rdy_c}, 32'd1);
        check("c_rx55_errs",  {29'd0, fe_c, pe_c, ov_c}, 32'd0);

        // Overrun on two uncleared frames, then clear
        pulse_clr_c();
        drive_frame(2, 16'h0222, 10);
        drive_frame(2, 16'h0244, 10);
        check("c_ovr_data",  {24'd0, rx_data_c}, 32'h22);
        check("c_ovr_flag",  {31'd0, ov_c}, 32'd1);
        check("c_ovr_ready", {31'd0, rdy_c}, 32'd1);
        pulse_clr_c();
        check("c_clr_flags", {28'd0, rdy_c, fe_c, pe_c, ov_c}, 32'd0);

        // Stop bit held low: data delivered, then no spurious frames while the line stays low
        drive_frame(2, 16'h01E0, 10);
        check("c_brk_ferr",  {31'd0, fe_c}, 32'd1);
        check("c_brk_ready", {31'd0, rdy_c}, 32'd1);
        check("c_brk_data",  {24'd0, rx_data_c}, 32'hF0);
        pulse_clr_c();
        repeat (12*BIT_F) @(negedge clk_100m);
        check("c_brk_hold", {31'd0, rdy_c}, 32'd0);
        set_rx(2, 1'b1);
        repeat (2*BIT_F) @(negedge clk_100m);
        check("c_brk_idle", {31'd0, rdy_c}, 32'd0);
        drive_frame(2, 16'h021E, 10);
        check("c_rec_data",  {24'd0, rx_data_c}, 32'h0F);
        check("c_rec_ferr",  {31'd0, fe_c}, 32'd0);
        check("c_rec_ready", {31'd0, rdy_c}, 32'd1);

        // tx_start while busy is dropped, not queued
        run_tx(2, 8'h81, BIT_F, 1'b1, busy_n, bits);
        check("c_tx_frame", {22'd0, bits[9:0]}, 32'h302);
        check("c_busy_len", {31'd0, (busy_n >= 10*BIT_F && busy_n <= 10*BIT_F + DIV_F)}, 32'd1);
        seen = 0;
        for (int i = 0; i < 2*BIT_F; i++) begin
            if (tx_busy_c) seen++;
            @(negedge clk_100m);
        end
        check("c_no_requeue", seen, 32'd0);

        // 7-bit loopback
        run_tx(3, 8'h5A, BIT_F, 1'b0, busy_n, bits);
        check("d_tx_frame", {23'd0, bits[8:0]}, 32'h1B4);
        check("d_busy_len", {31'd0, (busy_n >= 9*BIT_F && busy_n <= 9*BIT_F + DIV_F)}, 32'd1);
        check("d_rx_data",  {25'd0, rx_data_d}, 32'h5A);
        check("d_rx_ready", {31'd0, rdy_d}, 32'd1);

        // Reset in the middle of a frame
        set_start(2, 1'b1, 8'h00);
        @(negedge clk_100m);
        set_start(2, 1'b0, 8'h00);
        repeat (3*BIT_F) @(negedge clk_100m);
        check("c_pre_busy", {31'd0, tx_busy_c}, 32'd1);
        check("c_pre_tx",   {31'd0, tx_c}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk_100m);
        check("c_rst_tx",    {31'd0, tx_c}, 32'd1);
        check("c_rst_busy",  {31'd0, tx_busy_c}, 32'd0);
        check("c_rst_ready", {31'd0, rdy_c}, 32'd0);
        check("c_rst_data",  {24'd0, rx_data_c}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_100m);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
